// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard controller for the five-stage MIPS pipeline. Produces
//               the PC / IF/ID / ID/EX / EX/MEM write-enable and flush
//               controls for load-use stalls, taken-branch flushes and
//               multi-cycle data-memory waits. A two-state FSM (RUN/WAIT)
//               tracks outstanding memory accesses.
//               Optional feature macro: HAZARD_STALL_CNT_EN builds a 16-bit
//               saturating stall-cycle counter on stallCount; otherwise
//               stallCount is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_useRt,
    input  logic        ex_memRead,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branchTaken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexFlush,
    output logic        exmemWrite,
    output logic        memWait,
    output logic [15:0] stallCount
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_eff;
    state_t w_state_next;
    logic   w_load_use;
    logic   w_freeze;

    // Next-state and output decode; reset forces the decode to see RUN
    always_comb begin
        w_state_eff  = rst ? ST_RUN : r_state;
        w_state_next = w_state_eff;
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        ifidFlush    = 1'b0;
        idexFlush    = 1'b0;
        exmemWrite   = 1'b1;

        // $0 is hard-wired zero, so a load targeting it never creates a hazard
        w_load_use = ex_memRead && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_useRt && (ex_rt == id_rt)));

        // In WAIT the freeze drops in the same cycle ready arrives
        if (w_state_eff == ST_WAIT) begin
            w_freeze = !mem_ready;
            if (mem_ready) begin
                w_state_next = ST_RUN;
            end
        end else begin
            w_freeze = mem_req && !mem_ready;
            if (w_freeze) begin
                w_state_next = ST_WAIT;
            end
        end

        if (w_freeze) begin
            // Everything held; branch/load-use inputs are held too and get
            // re-evaluated once the access completes
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            exmemWrite = 1'b0;
        end else if (ex_branchTaken) begin
            // Squash IF/ID and ID/EX; the ID instruction of any load-use is gone
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle and push a bubble into EX
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            idexFlush = 1'b1;
        end

        memWait = (w_state_eff == ST_WAIT);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (!pcWrite && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stallCount = r_stall_cnt;
`else
    assign stallCount = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed vector table,
//               hand-written multi-cycle sequences and randomized traffic
//               against a behavioural model of the hazard rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_useRt;
    logic        ex_memRead;
    logic [4:0]  ex_rt;
    logic        ex_branchTaken;
    logic        mem_req;
    logic        mem_ready;
    logic        pcWrite;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexFlush;
    logic        exmemWrite;
    logic        memWait;
    logic [15:0] stallCount;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_useRt       (id_useRt),
        .ex_memRead     (ex_memRead),
        .ex_rt          (ex_rt),
        .ex_branchTaken (ex_branchTaken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pcWrite        (pcWrite),
        .ifidWrite      (ifidWrite),
        .ifidFlush      (ifidFlush),
        .idexFlush      (idexFlush),
        .exmemWrite     (exmemWrite),
        .memWait        (memWait),
        .stallCount     (stallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       req;
        logic       rdy;
    } vec_t;

    typedef struct packed {
        vec_t       v;
        logic [5:0] exp;   // {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memWait}
    } tvec_t;

    wire [5:0] dut_ctrl = {pcWrite, ifidWrite, ifidFlush, idexFlush, exmemWrite, memWait};

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: is a data-memory access outstanding, and stall count
    bit m_wait = 1'b0;
    int m_cnt  = 0;

    function automatic vec_t mk(input bit r, input int rs, input int rt, input bit ur,
                                input bit mr, input int ert, input bit br,
                                input bit rq, input bit rd);
        vec_t v;
        v.rst = r; v.rs = rs[4:0]; v.rt = rt[4:0]; v.use_rt = ur;
        v.mem_read = mr; v.ex_rt = ert[4:0]; v.br = br; v.req = rq; v.rdy = rd;
        return v;
    endfunction

    // Control outputs straight from the hazard rules
    function automatic logic [5:0] model_ctrl(input vec_t v, input bit waiting);
        bit in_wait;
        bit hazard_src;
        bit load_use;
        bit mem_busy;
        in_wait    = waiting && !v.rst;
        hazard_src = (v.ex_rt == v.rs) || (v.use_rt && v.ex_rt == v.rt);
        load_use   = v.mem_read && (v.ex_rt != 0) && hazard_src;
        // Stalled on memory if an access is pending (old or new) and not done now
        mem_busy   = (in_wait || v.req) && !v.rdy;
        if (mem_busy)       return {5'b00000, in_wait};
        else if (v.br)      return {5'b11111, in_wait};
        else if (load_use)  return {5'b00011, in_wait};
        else                return {5'b11001, in_wait};
    endfunction

    task automatic apply(input vec_t v, input bit chk, input string name,
                         input bit use_exp, input logic [5:0] exp);
        logic [5:0]  m;
        logic [15:0] mc;
        rst = v.rst; id_rs = v.rs; id_rt = v.rt; id_useRt = v.use_rt;
        ex_memRead = v.mem_read; ex_rt = v.ex_rt; ex_branchTaken = v.br;
        mem_req = v.req; mem_ready = v.rdy;
        #4;
        m = model_ctrl(v, m_wait);
`ifdef HAZARD_STALL_CNT_EN
        mc = m_cnt[15:0];
`else
        mc = 16'h0000;
`endif
        if (chk) begin
            n_vec++;
            if ({dut_ctrl, stallCount} !== {m, mc}) begin
                n_fail++;
                $display("FAIL %s model: got ctrl=%b cnt=%h, expected ctrl=%b cnt=%h",
                         name, dut_ctrl, stallCount, m, mc);
            end
            if (use_exp) begin
                n_vec++;
                if (dut_ctrl !== exp) begin
                    n_fail++;
                    $display("FAIL %s table: got ctrl=%b, expected ctrl=%b", name, dut_ctrl, exp);
                end
            end
        end
        // Advance model across the edge
        if (v.rst) begin
            m_wait = 1'b0;
            m_cnt  = 0;
        end else begin
            if (m_wait) m_wait = !v.rdy;
            else        m_wait = v.req && !v.rdy;
            if (!m[5] && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [15:0] exp);
        n_vec++;
        if (stallCount !== exp) begin
            n_fail++;
            $display("FAIL %s: got stallCount=%h, expected %h", name, stallCount, exp);
        end
    endtask

    tvec_t tbl[$];
    vec_t  idle;
    vec_t  rv;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Directed table, applied back to back starting from RUN
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b110010});  // default
        tbl.push_back('{mk(0, 5, 0, 0, 1, 5, 0, 0, 0), 6'b000110});  // load-use on rs
        tbl.push_back('{mk(0, 5, 0, 0, 0, 5, 0, 0, 0), 6'b110010});  // bubble, no load
        tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 6'b110010});  // $0 filtered
        tbl.push_back('{mk(0, 3, 7, 0, 1, 7, 0, 0, 0), 6'b110010});  // rt not used
        tbl.push_back('{mk(0, 3, 7, 1, 1, 7, 0, 0, 0), 6'b000110});  // rt used
        tbl.push_back('{mk(0, 5, 0, 0, 1, 5, 1, 0, 0), 6'b111110});  // branch beats load-use
        tbl.push_back('{mk(0, 1, 2, 1, 0, 4, 1, 0, 0), 6'b111110});  // plain branch
        tbl.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b110010});  // same-cycle ready
        tbl.push_back('{mk(0, 6, 0, 0, 1, 6, 0, 1, 1), 6'b000110});  // ready + load-use
        tbl.push_back('{mk(1, 6, 0, 0, 1, 6, 0, 0, 0), 6'b000110});  // decode under rst
        tbl.push_back('{mk(0, 6, 0, 0, 1, 6, 1, 1, 0), 6'b000000});  // freeze beats branch
        tbl.push_back('{mk(0, 6, 0, 0, 1, 6, 1, 1, 1), 6'b111111});  // release, branch, still WAIT

        rst = 1'b1; id_rs = '0; id_rt = '0; id_useRt = 1'b0; ex_memRead = 1'b0;
        ex_rt = '0; ex_branchTaken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "reset", 1, 6'b110010);
        check_cnt("reset_cnt", 16'h0000);

        foreach (tbl[i]) apply(tbl[i].v, 1, $sformatf("tbl%0d", i), 1, tbl[i].exp);

        // Memory wait: ready three cycles late
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "mw_rst", 0, 6'b0);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1, "mw_req", 1, 6'b000000);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1, "mw_wait1", 1, 6'b000001);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1, "mw_wait2", 1, 6'b000001);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 1, "mw_ready", 1, 6'b110011);
`ifdef HAZARD_STALL_CNT_EN
        check_cnt("mw_cnt", 16'd3);
`endif
        // Back-to-back request re-enters WAIT with no idle cycle
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1, "b2b_req", 1, 6'b000000);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1, "b2b_wait", 1, 6'b000001);

        // Reset while waiting
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1, "rw_rst", 1, 6'b110010);
        apply(idle, 1, "rw_after", 1, 6'b110010);
        check_cnt("rw_cnt", 16'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rv = mk(($urandom_range(63) == 0), $urandom_range(3), $urandom_range(3),
                    $urandom_range(1), $urandom_range(1), $urandom_range(3),
                    ($urandom_range(7) == 0), ($urandom_range(2) == 0),
                    $urandom_range(1));
            apply(rv, 1, "rand", 0, 6'b0);
        end

`ifdef HAZARD_STALL_CNT_EN
        // Saturation
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 0, "sat_rst", 0, 6'b0);
        for (int i = 0; i < 65537; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 0, "sat", 0, 6'b0);
        check_cnt("sat_cnt", 16'hFFFF);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 1, "sat_hold", 0, 6'b0);
        check_cnt("sat_hold_cnt", 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
